// File: rtl/conversor_int_para_float.sv
// Signed 32-bit integer to custom float (1/6/25) converter.
// Iterative normaliser, optional round-to-nearest-even, registered result.
module conversor_int_para_float #(
    parameter int BIAS          = 31,
    parameter bit ROUND_NEAREST = 1'b0
) (
    input  logic        clock_100kHz,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_NORMALIZE,
        S_ROUND,
        S_PACK
    } state_t;

    localparam logic [6:0] EXP_INIT    = 7'(BIAS + 31);
    localparam logic [6:0] EXP_MAX     = 7'd63;
    localparam logic [3:0] ST_EXACT    = 4'd0;
    localparam logic [3:0] ST_OVERFLOW = 4'd1;
    localparam logic [3:0] ST_INEXACT  = 4'd3;

    state_t      state, state_n;
    logic [31:0] int_q, int_n;
    logic        sign_q, sign_n;
    logic [31:0] mag_q, mag_n;
    logic [6:0]  exp_q, exp_n;
    logic [24:0] frac_q, frac_n;
    logic        inexact_q, inexact_n;
    logic        zero_q, zero_n;
    logic        done_n;
    logic [31:0] data_n;
    logic [3:0]  status_n;

    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [25:0] frac_sum;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            int_q      <= '0;
            sign_q     <= 1'b0;
            mag_q      <= '0;
            exp_q      <= '0;
            frac_q     <= '0;
            inexact_q  <= 1'b0;
            zero_q     <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            state      <= state_n;
            int_q      <= int_n;
            sign_q     <= sign_n;
            mag_q      <= mag_n;
            exp_q      <= exp_n;
            frac_q     <= frac_n;
            inexact_q  <= inexact_n;
            zero_q     <= zero_n;
            done       <= done_n;
            data_out   <= data_n;
            status_out <= status_n;
        end
    end

    always_comb begin
        state_n   = state;
        int_n     = int_q;
        sign_n    = sign_q;
        mag_n     = mag_q;
        exp_n     = exp_q;
        frac_n    = frac_q;
        inexact_n = inexact_q;
        zero_n    = zero_q;
        done_n    = 1'b0;
        data_n    = data_out;
        status_n  = status_out;
        guard     = mag_q[5];
        sticky    = |mag_q[4:0];
        round_up  = ROUND_NEAREST && guard && (sticky || mag_q[6]);
        frac_sum  = {1'b0, mag_q[30:6]} + 26'(round_up);

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    int_n   = int_in;
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                sign_n    = int_q[31];
                mag_n     = int_q[31] ? (~int_q + 32'd1) : int_q;
                exp_n     = EXP_INIT;
                frac_n    = '0;
                inexact_n = 1'b0;
                zero_n    = (int_q == 32'd0);
                state_n   = (int_q == 32'd0) ? S_PACK : S_NORMALIZE;
            end
            S_NORMALIZE: begin
                if (mag_q[31]) begin
                    state_n = S_ROUND;
                end else begin
                    mag_n = mag_q << 1;
                    exp_n = exp_q - 7'd1;
                end
            end
            S_ROUND: begin
                inexact_n = |mag_q[5:0];
                // A carry out of the fraction means the mantissa became 2.0
                if (frac_sum[25]) begin
                    frac_n = '0;
                    exp_n  = exp_q + 7'd1;
                end else begin
                    frac_n = frac_sum[24:0];
                end
                state_n = S_PACK;
            end
            S_PACK: begin
                done_n  = 1'b1;
                state_n = S_IDLE;
                if (zero_q) begin
                    data_n   = '0;
                    status_n = ST_EXACT;
                end else if (exp_q >= EXP_MAX) begin
                    data_n   = {sign_q, 6'h3F, 25'h0};
                    status_n = ST_OVERFLOW;
                end else begin
                    data_n   = {sign_q, exp_q[5:0], frac_q};
                    status_n = inexact_q ? ST_INEXACT : ST_EXACT;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_conversor_int_para_float.sv
// Directed bench for conversor_int_para_float: three parameterisations
// share stimulus; vector table plus abort and mid-run start sequences.
module tb_conversor_int_para_float;

    logic        clock_100kHz = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] int_in;

    logic        busy0, done0, busy1, done1, busy2, done2;
    logic [31:0] data0, data1, data2;
    logic [3:0]  st0, st1, st2;

    int checks = 0;
    int errors = 0;

    always #5 clock_100kHz = ~clock_100kHz;

    conversor_int_para_float #(.BIAS(31), .ROUND_NEAREST(1'b0)) u0 (
        .clock_100kHz(clock_100kHz), .reset(reset), .start(start),
        .int_in(int_in), .busy(busy0), .done(done0),
        .data_out(data0), .status_out(st0)
    );

    conversor_int_para_float #(.BIAS(31), .ROUND_NEAREST(1'b1)) u1 (
        .clock_100kHz(clock_100kHz), .reset(reset), .start(start),
        .int_in(int_in), .busy(busy1), .done(done1),
        .data_out(data1), .status_out(st1)
    );

    conversor_int_para_float #(.BIAS(40), .ROUND_NEAREST(1'b0)) u2 (
        .clock_100kHz(clock_100kHz), .reset(reset), .start(start),
        .int_in(int_in), .busy(busy2), .done(done2),
        .data_out(data2), .status_out(st2)
    );

    typedef struct {
        logic [31:0] din;
        logic [31:0] d0;
        logic [3:0]  s0;
        logic [31:0] d1;
        logic [3:0]  s1;
        logic [31:0] d2;
        logic [3:0]  s2;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Accept on edge 0, then count edges until done; -1 on timeout.
    task automatic convert(input logic [31:0] v, output int lat,
                           output logic busy_drop);
        @(negedge clock_100kHz);
        int_in = v;
        start  = 1'b1;
        @(posedge clock_100kHz);
        #1;
        start     = 1'b0;
        int_in    = ~v;
        lat       = -1;
        busy_drop = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock_100kHz);
            #1;
            if (done0) begin
                lat = n;
                break;
            end
            if (!busy0) busy_drop = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        int   extra;
        logic bd;

        vecs[0]  = '{32'h00000001, 32'h3E000000, 4'd0, 32'h3E000000, 4'd0,
                     32'h50000000, 4'd0, 35};
        vecs[1]  = '{32'hFFFFFFFA, 32'hC3000000, 4'd0, 32'hC3000000, 4'd0,
                     32'hD5000000, 4'd0, 33};
        vecs[2]  = '{32'h00000000, 32'h00000000, 4'd0, 32'h00000000, 4'd0,
                     32'h00000000, 4'd0, 2};
        vecs[3]  = '{32'h7FFFFFFF, 32'h7BFFFFFF, 4'd3, 32'h7C000000, 4'd3,
                     32'h7E000000, 4'd1, 5};
        vecs[4]  = '{32'h80000000, 32'hFC000000, 4'd0, 32'hFC000000, 4'd0,
                     32'hFE000000, 4'd1, 4};
        vecs[5]  = '{32'h40000000, 32'h7A000000, 4'd0, 32'h7A000000, 4'd0,
                     32'h7E000000, 4'd1, 5};
        vecs[6]  = '{32'h40000010, 32'h7A000000, 4'd3, 32'h7A000000, 4'd3,
                     32'h7E000000, 4'd1, 5};
        vecs[7]  = '{32'h40000030, 32'h7A000001, 4'd3, 32'h7A000002, 4'd3,
                     32'h7E000000, 4'd1, 5};
        vecs[8]  = '{32'h40000011, 32'h7A000000, 4'd3, 32'h7A000001, 4'd3,
                     32'h7E000000, 4'd1, 5};
        vecs[9]  = '{32'h4000000F, 32'h7A000000, 4'd3, 32'h7A000000, 4'd3,
                     32'h7E000000, 4'd1, 5};
        vecs[10] = '{32'hFFFFFFFF, 32'hBE000000, 4'd0, 32'hBE000000, 4'd0,
                     32'hD0000000, 4'd0, 35};
        vecs[11] = '{32'h12345678, 32'h76468ACF, 4'd0, 32'h76468ACF, 4'd0,
                     32'h7E000000, 4'd1, 7};

        reset  = 1'b1;
        start  = 1'b0;
        int_in = '0;
        #12;
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_data", data0, 32'd0);
        chk("rst_status", {28'd0, st0}, 32'd0);
        @(negedge clock_100kHz);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].din, lat, bd);
            chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy", i), {31'd0, bd}, 32'd0);
            chk($sformatf("v%0d_done12", i), {30'd0, done1, done2}, 32'd3);
            chk($sformatf("v%0d_data0", i), data0, vecs[i].d0);
            chk($sformatf("v%0d_st0", i), {28'd0, st0}, {28'd0, vecs[i].s0});
            chk($sformatf("v%0d_data1", i), data1, vecs[i].d1);
            chk($sformatf("v%0d_st1", i), {28'd0, st1}, {28'd0, vecs[i].s1});
            chk($sformatf("v%0d_data2", i), data2, vecs[i].d2);
            chk($sformatf("v%0d_st2", i), {28'd0, st2}, {28'd0, vecs[i].s2});
            @(posedge clock_100kHz);
            #1;
            chk($sformatf("v%0d_pulse", i), {31'd0, done0}, 32'd0);
        end

        // Second start mid-conversion must be ignored
        @(negedge clock_100kHz);
        int_in = 32'h00000001;
        start  = 1'b1;
        @(posedge clock_100kHz);
        #1;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock_100kHz);
            start  = (n == 10);
            int_in = (n == 10) ? 32'h00000005 : 32'hDEADBEEF;
            @(posedge clock_100kHz);
            #1;
            if (done0) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk("mid_start_lat", lat, 35);
        chk("mid_start_data", data0, 32'h3E000000);
        chk("mid_start_status", {28'd0, st0}, 32'd0);
        extra = 0;
        repeat (45) begin
            @(posedge clock_100kHz);
            #1;
            if (done0) extra++;
        end
        chk("mid_start_extra_done", extra, 0);

        // Abort during NORMALIZE
        @(negedge clock_100kHz);
        int_in = 32'h00000001;
        start  = 1'b1;
        @(posedge clock_100kHz);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clock_100kHz);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_done", {31'd0, done0}, 32'd0);
        chk("abort_data", data0, 32'd0);
        chk("abort_status", {28'd0, st0}, 32'd0);
        repeat (2) @(negedge clock_100kHz);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(posedge clock_100kHz);
            #1;
            if (done0) extra++;
        end
        chk("abort_no_done", extra, 0);
        convert(32'hFFFFFFFA, lat, bd);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_data", data0, 32'hC3000000);
        chk("post_rst_status", {28'd0, st0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conversor_int_para_float.md
Name: conversor_int_para_float

Overview:
- Sequential signed-32-bit-integer to custom 32-bit float encoder; produces the operands consumed by the float adder (op_A_in/op_B_in format).
- Float format: bit 31 sign, bits 30:25 exponent (6 b), bits 24:0 fraction (25 b, hidden leading 1).
- Value = (-1)^s x 1.f x 2^(e-BIAS); encoding 0x00000000 = zero; exponent 63 reserved for overflow.
- Iterative normaliser (one left shift per clock), then rounding, then pack; start/busy/done handshake; status codes match the adder.

Parameters:
- BIAS, 31, exponent bias; legal range 1..62.
- ROUND_NEAREST, 0, 0 = truncate (toward zero); 1 = round-to-nearest-even.

Ports:
- clock_100kHz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- int_in  input  32  two's-complement integer; latched on the edge that accepts start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when data_out/status_out are updated.
- data_out  output  32  encoded float; held until the next done.
- status_out  output  4  0 exact, 1 overflow, 2 underflow (reserved, never produced), 3 inexact.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, data_out=0, status_out=0; internal regs cleared; an in-flight conversion is discarded with no done.
- States: IDLE -> LOAD -> NORMALIZE (loops) -> ROUND -> PACK -> IDLE.
- IDLE: if start=1, latch int_in and go to LOAD; done=0. start in any other state is ignored; int_in changes after acceptance have no effect.
- LOAD: sign = int_in[31]; mag (32 b, unsigned) = |int_in| (0x80000000 gives 2^31); exp (7 b) = BIAS+31. If mag=0, go to PACK with a zero flag.
- NORMALIZE: if mag[31]=1, go to ROUND; else mag <<= 1, exp -= 1, stay. Runs 32-p cycles, where p is the leading-one index of mag.
- ROUND: frac = mag[30:6]; guard = mag[5]; sticky = |mag[4:0]; inexact = |mag[5:0].
  - ROUND_NEAREST=1: frac += guard & (sticky | frac[0]). A carry out of the 25-bit frac sets frac=0 and exp+=1.
  - ROUND_NEAREST=0: frac unchanged.
- PACK: set done=1 for exactly one cycle; busy stays high this cycle and deasserts on return to IDLE.
  - zero flag: data_out=0x00000000, status 0.
  - exp>=63: data_out={sign,6'h3F,25'h0}, status 1.
  - otherwise: data_out={sign,exp[5:0],frac}; status 3 if inexact, else 0.
  - Precedence: overflow > inexact > exact.
- Latency: the accepting edge is edge 0; done goes high after edge 35-p (p=31 gives 4; p=0 gives 35). Zero input: done after edge 2.
- A new start is accepted on the first IDLE cycle after PACK; back-to-back conversions have no bubble beyond that.
- With BIAS=31 overflow is unreachable (max exp 62, including rounding carry from 2^31-1). Overflow is reachable with BIAS>31.

Test Plan:
- int_in=1, defaults -> data_out=0x3E000000, status 0, done 35 edges after accept, single-cycle pulse, busy=1 throughout.
- int_in=-6 (0xFFFFFFFA) -> 0xC3000000, status 0, done after 33 edges. Then int_in=0 -> 0x00000000, status 0, done after 2 edges.
- int_in=0x7FFFFFFF: ROUND_NEAREST=0 -> 0x7BFFFFFF, status 3; ROUND_NEAREST=1 -> 0x7C000000, status 3 (rounding carry into exponent).
- int_in=0x80000000 -> 0xFC000000, status 0, done after 4 edges. BIAS=40, int_in=0x40000000 -> 0x7E000000, status 1.
- Start pulsed again mid-conversion with a different int_in -> ignored; first result unchanged; no extra done.
- reset asserted mid-NORMALIZE -> immediate busy=0, data_out=0, status 0, no done. After reset release, a fresh start converts correctly.
